rr_req_arbiter: RTL and testbench
=================================

Name: rr_req_arbiter

Overview:
- Round-robin arbiter that shares one service resource among 12 request lines.
- Lines are slide switches/buttons, already inverted to active-high upstream.
- Grants exactly one requester at a time and holds the grant until that requester releases.
- Also publishes the index of the next requester in line, so the 7-segment test circuit can show "current" and "next" on two digits through hex_to_sseg and the display mux.

Parameters:
- N, 12, number of request lines (2..16)
- IDXW, 4, width of index outputs; must satisfy 2^IDXW >= N
- HOLD_MAX, 50_000_000, maximum grant length in clk cycles (used only with the timeout feature)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- req  input  N  active-high request vector, one bit per requester
- grant  output  N  one-hot grant; all zero when nothing is granted
- grant_valid  output  1  high while a grant is held
- grant_idx  output  IDXW  index of the granted requester; 0 when grant_valid is low
- next_valid  output  1  high if another requester is waiting
- next_idx  output  IDXW  index that will be granted next; 0 when next_valid is low
- timeout  output  1  one-cycle pulse when a grant is forcibly ended

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE, ptr=0, and all outputs 0. This applies immediately, including mid-grant.
- ptr holds the highest-priority index. Search order is ptr, ptr+1, ..., N-1, 0, ..., ptr-1, and wraps modulo N.
- States:
  - IDLE: no grant held. If req != 0, register the search winner into grant/grant_idx, set grant_valid=1, go to GRANT. Latency: req rising edge to grant_valid is 1 clk.
  - GRANT: hold the grant while req[grant_idx]=1. When req[grant_idx]=0 is sampled:
    - clear grant, grant_valid and grant_idx on that edge;
    - set ptr <= grant_idx+1, with N-1 wrapping to 0;
    - go to GAP.
  - GAP: exactly one cycle with no grant, giving the resource a guaranteed idle cycle. If req != 0, register the winner searched from the updated ptr and go to GRANT; otherwise go to IDLE.
- Re-grant timing: req drop to the next grant is 2 clk edges.
- Other requests arriving during GRANT do not preempt the holder.
- next_idx/next_valid are registered every cycle:
  - in GRANT: winner of a search from grant_idx+1 that excludes grant_idx;
  - in IDLE/GAP: winner of a search from ptr.
  - next_valid=0 if no eligible bit is set.
- A requester releasing and immediately re-asserting is served again only after every other pending requester has been served once.
- In the same cycle, release takes precedence over any other event.
- grant is always one-hot or zero, and always consistent with grant_idx/grant_valid.
- Bits of req above N-1 do not exist. With N < 2^IDXW, indices >= N are never produced.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - a grant counter starts at 0 on entering GRANT and increments each GRANT cycle;
  - when it reaches HOLD_MAX-1 while req[grant_idx] is still 1, the arbiter releases exactly as for a normal release (ptr advance, GAP) and pulses timeout for one cycle, coincident with grant clearing;
  - if release and timeout coincide, it is a normal release and timeout stays 0.
- Not defined: no counter is built, a grant is held indefinitely, and timeout is tied to 0.

Decomposition:
- Shared include arb_defs.vh holds:
  - state encodings: IDLE=2'd0, GRANT=2'd1, GAP=2'd2;
  - the default N/IDXW constants.
- One natural sub-module, rr_prio_search:
  - combinational rotating priority encoder;
  - inputs: req vector, start index, exclude mask;
  - outputs: winner index and found flag.
  - Instantiated twice: once for the grant winner, once for next.

Test Plan:
- Reset, req=12'h000: all outputs 0. Assert reset_n=0 mid-grant: grant clears without waiting for a clock edge.
- req=12'h801 from reset (ptr=0): 1 clk later grant_idx=0, next_idx=11. Drop bit 0: grant clears; 2 edges after the drop grant_idx=11, next_valid=0.
- req=12'hFFF held, each holder drops and re-asserts after 3 cycles: grant_idx sequence is 0,1,...,11,0 with exactly one GAP cycle between grants.
- Holder idx=5, bits 2 and 9 asserted meanwhile: no preemption; next_idx=9. After release, grant goes to 9, then 2.
- ARB_TIMEOUT_EN with HOLD_MAX=8, req=12'h010 held: grant lasts 8 cycles, timeout pulses once, one GAP cycle follows, then idx 4 is re-granted.
- Check after every cycle: grant is one-hot/zero, grant matches grant_idx, and grant_valid=|grant.

Source files
------------

// File: rtl/rr_req_arbiter_pkg.sv
// Shared types and default sizing for the round-robin request arbiter.
// Replaces the old arb_defs.vh state encodings and default constants.
package rr_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int unsigned ARB_N        = 12;
  localparam int unsigned ARB_IDXW     = 4;
  localparam int unsigned ARB_HOLD_MAX = 50_000_000;

endpackage

// File: rtl/rr_req_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_req_arbiter_if
  import rr_req_arbiter_pkg::*;
#(
  parameter int unsigned N    = ARB_N,
  parameter int unsigned IDXW = ARB_IDXW
);
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [IDXW-1:0] grant_idx;
  logic            next_valid;
  logic [IDXW-1:0] next_idx;
  logic            timeout;

  modport master (
    output req,
    input  grant, grant_valid, grant_idx, next_valid, next_idx, timeout
  );

  modport slave (
    input  req,
    output grant, grant_valid, grant_idx, next_valid, next_idx, timeout
  );
endinterface

// File: rtl/rr_req_arbiter_prio_search.sv
// Combinational rotating priority encoder: first set, non-excluded bit
// found scanning start_i, start_i+1, ... modulo N.
module rr_prio_search
  import rr_req_arbiter_pkg::*;
#(
  parameter int unsigned N    = ARB_N,
  parameter int unsigned IDXW = ARB_IDXW
) (
  input  logic [N-1:0]    req_i,
  input  logic [IDXW-1:0] start_i,
  input  logic [N-1:0]    excl_i,
  output logic [IDXW-1:0] idx_o,
  output logic            found_o
);
  logic [N-1:0] cand;

  assign cand = req_i & ~excl_i;

  always_comb begin
    int unsigned  pos;
    logic [N-1:0] sh;
    idx_o   = '0;
    found_o = 1'b0;
    pos     = 0;
    sh      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(start_i) + k;
      if (pos >= N) pos = pos - N;
      sh = cand >> pos;
      if (!found_o && sh[0]) begin
        found_o = 1'b1;
        idx_o   = IDXW'(pos);
      end
    end
  end
endmodule

// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter: holds one grant until release, publishes the next in line.
// Optional forced release after HOLD_MAX cycles when ARB_TIMEOUT_EN is defined.
module rr_req_arbiter
  import rr_req_arbiter_pkg::*;
#(
  parameter int unsigned N        = ARB_N,
  parameter int unsigned IDXW     = ARB_IDXW,
  parameter int unsigned HOLD_MAX = ARB_HOLD_MAX
) (
  input  logic             clk,
  input  logic             reset_n,
  rr_req_arbiter_if.slave  bus
);
  arb_state_e      state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] gidx_q, gidx_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            gvalid_q, gvalid_d;
  logic [IDXW-1:0] nidx_q;
  logic            nvalid_q;

  logic [IDXW-1:0] win_idx, nxt_idx, nxt_start;
  logic            win_found, nxt_found;
  logic [N-1:0]    nxt_excl;
  logic            held, expire;

  if (N < 2 || N > 16 || (1 << IDXW) < N || HOLD_MAX == 0) begin : g_bad_cfg
    $error("rr_req_arbiter: illegal N/IDXW/HOLD_MAX combination");
  end

  function automatic logic [IDXW-1:0] wrap_inc(input logic [IDXW-1:0] i);
    return (i == IDXW'(N - 1)) ? '0 : i + IDXW'(1);
  endfunction

  assign held = |(bus.req & grant_q);

  rr_prio_search #(.N(N), .IDXW(IDXW)) u_win (
    .req_i   (bus.req),
    .start_i (ptr_q),
    .excl_i  ({N{1'b0}}),
    .idx_o   (win_idx),
    .found_o (win_found)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    gvalid_d = gvalid_q;
    unique case (state_q)
      IDLE, GAP: begin
        if (win_found) begin
          state_d  = GRANT;
          gidx_d   = win_idx;
          grant_d  = {{(N-1){1'b0}}, 1'b1} << win_idx;
          gvalid_d = 1'b1;
        end else begin
          state_d  = IDLE;
          gidx_d   = '0;
          grant_d  = '0;
          gvalid_d = 1'b0;
        end
      end
      GRANT: begin
        if (!held || expire) begin
          state_d  = GAP;
          ptr_d    = wrap_inc(gidx_q);
          gidx_d   = '0;
          grant_d  = '0;
          gvalid_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        gidx_d   = '0;
        grant_d  = '0;
        gvalid_d = 1'b0;
      end
    endcase
  end

  // "next" is computed against the post-edge state so it is current the
  // same cycle the grant it refers to becomes visible.
  assign nxt_start = (state_d == GRANT) ? wrap_inc(gidx_d) : ptr_d;
  assign nxt_excl  = (state_d == GRANT) ? grant_d : '0;

  rr_prio_search #(.N(N), .IDXW(IDXW)) u_nxt (
    .req_i   (bus.req),
    .start_i (nxt_start),
    .excl_i  (nxt_excl),
    .idx_o   (nxt_idx),
    .found_o (nxt_found)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      gvalid_q <= 1'b0;
      nidx_q   <= '0;
      nvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      gvalid_q <= gvalid_d;
      nidx_q   <= nxt_found ? nxt_idx : '0;
      nvalid_q <= nxt_found;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  logic [CW-1:0] cnt_q;
  logic          timeout_q;

  assign expire = (state_q == GRANT) && (cnt_q == CW'(HOLD_MAX - 1));

  // A release coinciding with expiry is a normal release: no pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire && held;
      if (state_q != GRANT) cnt_q <= '0;
      else                  cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.grant       = grant_q;
  assign bus.grant_valid = gvalid_q;
  assign bus.grant_idx   = gidx_q;
  assign bus.next_valid  = nvalid_q;
  assign bus.next_idx    = nidx_q;
endmodule

// File: tb/tb_rr_req_arbiter.sv
// Randomised self-checking bench for rr_req_arbiter against a queue/int reference model.
module tb_rr_req_arbiter;
  localparam int N        = 12;
  localparam int IDXW     = 4;
  localparam int HOLD_MAX = 8;

  logic clk = 1'b0;
  logic reset_n;

  rr_req_arbiter_if #(.N(N), .IDXW(IDXW)) bus ();

  rr_req_arbiter #(.N(N), .IDXW(IDXW), .HOLD_MAX(HOLD_MAX)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who holds the grant (-1 = nobody), priority pointer,
  // cycles held so far, expected next requester, expected timeout pulse.
  int m_holder = -1;
  int m_ptr    = 0;
  int m_cnt    = 0;
  int m_next   = -1;
  bit m_to     = 1'b0;
  int seq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_ptr    = 0;
    m_cnt    = 0;
    m_next   = -1;
    m_to     = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r);
    bit rel, exp_hit;
    m_to = 1'b0;
    if (m_holder >= 0) begin
      rel = !r[m_holder];
`ifdef ARB_TIMEOUT_EN
      exp_hit = (m_cnt == HOLD_MAX - 1);
`else
      exp_hit = 1'b0;
`endif
      if (rel || exp_hit) begin
        m_to     = !rel;
        m_ptr    = (m_holder + 1) % N;
        m_holder = -1;
      end else begin
        m_cnt++;
      end
    end else begin
      int w;
      w = pick(r, m_ptr, -1);
      if (w >= 0) begin
        m_holder = w;
        m_cnt    = 0;
        seq.push_back(w);
      end
    end
    m_next = (m_holder >= 0) ? pick(r, (m_holder + 1) % N, m_holder) : pick(r, m_ptr, -1);
  endtask

  task automatic check_outputs();
    check("grant",       32'(bus.grant),       (m_holder >= 0) ? (32'd1 << m_holder) : 32'd0);
    check("grant_valid", 32'(bus.grant_valid), 32'(m_holder >= 0));
    check("grant_idx",   32'(bus.grant_idx),   (m_holder >= 0) ? 32'(m_holder) : 32'd0);
    check("next_valid",  32'(bus.next_valid),  32'(m_next >= 0));
    check("next_idx",    32'(bus.next_idx),    (m_next >= 0) ? 32'(m_next) : 32'd0);
    check("timeout",     32'(bus.timeout),     32'(m_to));
    check("onehot0",     32'($onehot0(bus.grant)), 32'd1);
    check("grant_vs_idx", 32'(bus.grant),
          bus.grant_valid ? (32'd1 << bus.grant_idx) : 32'd0);
    check("gv_is_or",    32'(bus.grant_valid), 32'(|bus.grant));
  endtask

  task automatic step(input logic [N-1:0] r);
    bus.req = r;
    @(posedge clk);
    #1;
    model_step(r);
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.req = '0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    int down[N];
    int held_cycles;

    bus.req = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(negedge clk);
    check_outputs();
    reset_n = 1'b1;
    step('0);
    step('0);

    // Two requesters from reset, release of the first.
    step(12'h801);
    check("t801_idx0",  32'(bus.grant_idx), 32'd0);
    check("t801_next",  32'(bus.next_idx),  32'd11);
    step(12'h801);
    step(12'h800);
    check("t801_gap",   32'(bus.grant_valid), 32'd0);
    step(12'h800);
    check("t801_idx11", 32'(bus.grant_idx),  32'd11);
    check("t801_nv0",   32'(bus.next_valid), 32'd0);

    // Asynchronous reset mid-grant, checked between clock edges.
    reset_n = 1'b0;
    #2;
    model_reset();
    check("async_clr", 32'(bus.grant), 32'd0);
    check_outputs();
    @(negedge clk);
    bus.req = '0;
    reset_n = 1'b1;

    // All requesting; each holder drops for 3 cycles after 2 cycles of grant.
    seq.delete();
    foreach (down[i]) down[i] = 0;
    held_cycles = 0;
    repeat (80) begin
      r = '1;
      for (int i = 0; i < N; i++) begin
        if (down[i] > 0) begin
          r[i] = 1'b0;
          down[i]--;
        end
      end
      step(r);
      if (m_holder >= 0) begin
        held_cycles++;
        if (held_cycles == 2) down[m_holder] = 3;
      end else begin
        held_cycles = 0;
      end
    end
    check("rot_count", 32'(seq.size() >= 13), 32'd1);
    for (int k = 0; k < 13 && k < seq.size(); k++)
      check("rot_order", 32'(seq[k]), 32'(k % N));

    // No preemption of holder 5; next follows round-robin order.
    do_reset();
    step(12'h020);
    repeat (3) step(12'h224);
    check("np_hold5", 32'(bus.grant_idx), 32'd5);
    check("np_next9", 32'(bus.next_idx),  32'd9);
    step(12'h204);
    step(12'h204);
    check("np_idx9",  32'(bus.grant_idx), 32'd9);
    step(12'h004);
    step(12'h004);
    check("np_idx2",  32'(bus.grant_idx), 32'd2);
    step('0);
    step('0);

    // Single long holder: forced release when the timeout feature is built.
    do_reset();
    repeat (30) step(12'h010);
    step('0);

    // Random traffic with sticky request bits.
    do_reset();
    r = '0;
    repeat (1500) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(5) == 0) r[i] = ~r[i];
      step(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
